dma_peripheral_endpoint: RTL and testbench

Device-side endpoint for one 8237 DMA channel: the responder that raises DREQ, answers DACK-qualified IOR/IOW strobes from the controller, and stops on EOP/terminal count. A byte FIFO buffers between a local device port (valid/ready) and the controller's I/O cycles. It sits behind a peripheral (floppy, HDD, sound) and connects to one dma_request/dma_acknowledge pair of the DMA controller.

---
 rtl/dma_peripheral_endpoint.sv | 187 ++++++++++++++++++
 tb/tb_dma_peripheral_endpoint.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_peripheral_endpoint.sv
// Device-side responder for one 8237 DMA channel: raises DREQ, answers DACK-qualified
// IOR/IOW strobes and stops on EOP, with a byte FIFO between the device port and the bus.
module dma_peripheral_endpoint #(
    parameter int FIFO_DEPTH    = 16,
    parameter int REQ_THRESHOLD = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic                         direction,
    input  logic                         tc_clear,
    input  logic [7:0]                   dev_in_data,
    input  logic                         dev_in_valid,
    output logic                         dev_in_ready,
    output logic [7:0]                   dev_out_data,
    output logic                         dev_out_valid,
    input  logic                         dev_out_ready,
    output logic                         dma_request,
    input  logic                         dma_acknowledge,
    input  logic                         io_read_n,
    input  logic                         io_write_n,
    input  logic                         end_of_process_n,
    input  logic [7:0]                   data_bus_in,
    output logic [7:0]                   data_bus_out,
    output logic                         terminal_count,
    output logic                         underrun,
    output logic                         overrun,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [2:0]                   dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_REQUEST  = 3'd2,
        S_TRANSFER = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t          r_state, w_next;
    logic            r_enable_d, r_dir, r_strobe_d, r_eop_seen, r_strobe_empty;
    logic            r_dreq, r_tc, r_underrun, r_overrun;
    logic [7:0]      r_capture;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]   r_level;

    logic            w_active, w_strobe, w_strobe_end, w_empty, w_full;
    logic            w_dev_push, w_dev_pop, w_bus_push, w_bus_pop, w_push, w_pop;
    logic            w_eop_end;
    logic [7:0]      w_head, w_push_data;
    logic [LW-1:0]   w_level_next;

    // DREQ condition: enough data to read (device->memory) or enough room to write.
    function automatic logic f_cond(input logic dir, input logic [LW-1:0] lvl);
        if (dir)
            return (LW'(FIFO_DEPTH) - lvl) >= LW'(REQ_THRESHOLD);
        return lvl >= LW'(REQ_THRESHOLD);
    endfunction

    assign w_active     = (r_state != S_IDLE);
    assign w_strobe     = w_active & dma_acknowledge & ~(r_dir ? io_write_n : io_read_n);
    assign w_strobe_end = w_active & r_strobe_d & ~w_strobe;
    assign w_empty      = (r_level == '0);
    assign w_full       = (r_level == LW'(FIFO_DEPTH));
    assign w_head       = r_mem[r_rd_ptr];

    // Device port handshake: a byte moves on any cycle where valid and ready are both high.
    assign dev_in_ready  = w_active & enable & ~r_dir & ~w_full;
    assign dev_out_valid = w_active & enable & r_dir & ~w_empty;
    assign dev_out_data  = w_head;
    assign w_dev_push    = dev_in_valid & dev_in_ready;
    assign w_dev_pop     = dev_out_valid & dev_out_ready;

    // A read strobe that ever saw an empty FIFO returned 0x00, so it must not consume a byte.
    assign w_bus_pop    = ~r_dir & w_strobe_end & ~r_strobe_empty & ~w_empty;
    assign w_bus_push   = r_dir & w_strobe_end & ~w_full;
    assign w_push       = w_dev_push | w_bus_push;
    assign w_pop        = w_bus_pop | w_dev_pop;
    assign w_push_data  = r_dir ? r_capture : dev_in_data;
    assign w_level_next = r_level + LW'(w_push) - LW'(w_pop);
    assign w_eop_end    = (r_state == S_TRANSFER) & w_strobe_end & r_eop_seen;

    assign data_bus_out   = (w_strobe & ~r_dir & ~w_empty) ? w_head : 8'h00;
    assign dma_request    = r_dreq;
    assign terminal_count = r_tc;
    assign underrun       = r_underrun;
    assign overrun        = r_overrun;
    assign fifo_level     = r_level;
    assign dbg_state      = r_state;

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (!r_enable_d) w_next = S_ARMED;
                S_ARMED:    if (f_cond(r_dir, r_level)) w_next = S_REQUEST;
                S_REQUEST:  if (w_strobe) w_next = S_TRANSFER;
                S_TRANSFER: begin
                    if (w_strobe_end) begin
                        if (r_eop_seen)
                            w_next = S_DONE;
                        else if (f_cond(r_dir, w_level_next))
                            w_next = S_REQUEST;
                        else
                            w_next = S_ARMED;
                    end
                end
                S_DONE:     if (tc_clear) w_next = S_ARMED;
                default:    w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_enable_d     <= 1'b0;
            r_dir          <= 1'b0;
            r_strobe_d     <= 1'b0;
            r_eop_seen     <= 1'b0;
            r_strobe_empty <= 1'b0;
            r_dreq         <= 1'b0;
            r_tc           <= 1'b0;
            r_underrun     <= 1'b0;
            r_overrun      <= 1'b0;
            r_capture      <= 8'h00;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
        end else begin
            r_state    <= w_next;
            r_enable_d <= enable;
            r_strobe_d <= w_strobe;
            r_dreq     <= (w_next == S_REQUEST) || (w_next == S_TRANSFER);
            if (r_state == S_IDLE && enable && !r_enable_d)
                r_dir <= direction;
            if (w_strobe)
                r_capture <= data_bus_in;

            if (w_strobe_end)
                r_eop_seen <= 1'b0;
            else if (w_strobe && !end_of_process_n)
                r_eop_seen <= 1'b1;

            if (w_strobe_end)
                r_strobe_empty <= 1'b0;
            else if (w_strobe && !r_dir && w_empty)
                r_strobe_empty <= 1'b1;

            if (r_state == S_IDLE) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                r_level <= w_level_next;
            end

            // Setting events take priority over a simultaneous tc_clear.
            if (w_eop_end)
                r_tc <= 1'b1;
            else if (tc_clear)
                r_tc <= 1'b0;

            if (w_strobe && !r_dir && w_empty)
                r_underrun <= 1'b1;
            else if (tc_clear)
                r_underrun <= 1'b0;

            if (r_dir && w_strobe_end && w_full)
                r_overrun <= 1'b1;
            else if (tc_clear)
                r_overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dma_peripheral_endpoint.sv
// Scoreboard bench for dma_peripheral_endpoint: a queue models the FIFO contents and a
// negedge monitor compares bus reads and device pops against it.
module tb_dma_peripheral_endpoint;
    localparam int DEPTH = 16;
    localparam int TH    = 1;

    logic       clock = 1'b0;
    logic       reset_n, enable, direction, tc_clear;
    logic [7:0] dev_in_data;
    logic       dev_in_valid, dev_in_ready;
    logic [7:0] dev_out_data;
    logic       dev_out_valid, dev_out_ready;
    logic       dma_request, dma_acknowledge, io_read_n, io_write_n, end_of_process_n;
    logic [7:0] data_bus_in, data_bus_out;
    logic       terminal_count, underrun, overrun;
    logic [4:0] fifo_level;
    logic [2:0] dbg_state;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         exp_underrun = 0;
    bit         exp_overrun  = 0;
    bit         mon_on = 0;
    bit         mon_in_strobe = 0;
    bit         mon_saw_empty = 0;
    bit         rnd_ready_on = 0;

    dma_peripheral_endpoint #(.FIFO_DEPTH(DEPTH), .REQ_THRESHOLD(TH)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .direction(direction),
        .tc_clear(tc_clear), .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid),
        .dev_in_ready(dev_in_ready), .dev_out_data(dev_out_data),
        .dev_out_valid(dev_out_valid), .dev_out_ready(dev_out_ready),
        .dma_request(dma_request), .dma_acknowledge(dma_acknowledge),
        .io_read_n(io_read_n), .io_write_n(io_write_n),
        .end_of_process_n(end_of_process_n), .data_bus_in(data_bus_in),
        .data_bus_out(data_bus_out), .terminal_count(terminal_count),
        .underrun(underrun), .overrun(overrun), .fifo_level(fifo_level),
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic dev_push(input logic [7:0] b);
        bit got = 0;
        dev_in_data  = b;
        dev_in_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            got = dev_in_ready;
            tick();
        end
        dev_in_valid = 1'b0;
        check("dev_push_accept", got, 1);
        if (got) exp_q.push_back(b);
    endtask

    task automatic bus_cycle(input int len, input int eop_idx, input logic [7:0] b);
        bit full_now;
        dma_acknowledge = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (direction) io_write_n = 1'b0; else io_read_n = 1'b0;
            end_of_process_n = (i == eop_idx) ? 1'b0 : 1'b1;
            data_bus_in = (i == len - 1) ? b : 8'($urandom);
            tick();
        end
        dma_acknowledge = 1'b0; io_read_n = 1'b1; io_write_n = 1'b1;
        end_of_process_n = 1'b1; data_bus_in = 8'h00;
        full_now = (exp_q.size() >= DEPTH);
        tick();
        if (direction) begin
            if (full_now) exp_overrun = 1'b1;
            else exp_q.push_back(b);
        end
    endtask

    task automatic wait_dreq(input logic v, input int budget, input string name);
        for (int i = 0; i < budget && dma_request !== v; i++) tick();
        check(name, dma_request, v);
    endtask

    task automatic pulse_tc_clear();
        tc_clear = 1'b1;
        tick();
        tc_clear = 1'b0;
        exp_underrun = 1'b0;
        exp_overrun  = 1'b0;
    endtask

    task automatic drain_dir0();
        for (int g = 0; g < 40 && exp_q.size() > 0; g++) begin
            wait_dreq(1'b1, 10, "drain_dreq");
            bus_cycle($urandom_range(1, 3), -1, 8'h00);
        end
        check("drain_level", fifo_level, 0);
        check("drain_dreq_low", dma_request, 0);
    endtask

    task automatic wait_dev_drain();
        for (int g = 0; g < 100 && exp_q.size() > 0; g++) tick();
        tick();
        check("dev_drain_level", fifo_level, 0);
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (mon_on) begin
            if (!direction) begin
                if (dma_acknowledge && !io_read_n) begin
                    mon_in_strobe = 1'b1;
                    if (exp_q.size() == 0) begin
                        mon_saw_empty = 1'b1;
                        exp_underrun  = 1'b1;
                        check("bus_read_empty", data_bus_out, 8'h00);
                    end else begin
                        check("bus_read_data", data_bus_out, exp_q[0]);
                    end
                end else if (mon_in_strobe) begin
                    mon_in_strobe = 1'b0;
                    if (!mon_saw_empty && exp_q.size() > 0) void'(exp_q.pop_front());
                    mon_saw_empty = 1'b0;
                end
            end else begin
                check("dev_out_valid", dev_out_valid, exp_q.size() != 0);
                if (dev_out_valid && dev_out_ready && exp_q.size() > 0)
                    check("dev_out_data", dev_out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; direction = 1'b0; tc_clear = 1'b0;
        dev_in_data = 8'h00; dev_in_valid = 1'b0; dev_out_ready = 1'b0;
        dma_acknowledge = 1'b0; io_read_n = 1'b1; io_write_n = 1'b1;
        end_of_process_n = 1'b1; data_bus_in = 8'h00;
        repeat (3) tick();
        check("rst_dreq", dma_request, 0);
        check("rst_bus", data_bus_out, 8'h00);
        check("rst_tc", terminal_count, 0);
        check("rst_underrun", underrun, 0);
        check("rst_overrun", overrun, 0);
        check("rst_level", fifo_level, 0);
        check("rst_in_ready", dev_in_ready, 0);
        check("rst_out_valid", dev_out_valid, 0);
        check("rst_state", dbg_state, 0);
        reset_n = 1'b1;
        tick();

        // device -> memory: single byte
        direction = 1'b0; enable = 1'b1;
        repeat (2) tick();
        mon_on = 1'b1;
        check("armed_dreq", dma_request, 0);
        dev_push(8'hA5);
        check("push_level", fifo_level, 1);
        check("dreq_before", dma_request, 0);
        tick();
        check("dreq_next_cycle", dma_request, 1);
        bus_cycle(3, -1, 8'h00);
        check("a5_level", fifo_level, 0);
        check("a5_dreq_low", dma_request, 0);

        // device -> memory: random bursts
        repeat (2) begin
            int n = $urandom_range(3, 8);
            for (int i = 0; i < n; i++) dev_push(8'($urandom));
            check("burst_level", fifo_level, exp_q.size());
            drain_dir0();
        end

        // EOP ignored outside a strobe, then honoured on the 3rd of 5
        for (int i = 0; i < 5; i++) dev_push(8'($urandom));
        wait_dreq(1'b1, 4, "eop_pre_dreq");
        end_of_process_n = 1'b0;
        repeat (2) tick();
        end_of_process_n = 1'b1;
        tick();
        check("eop_idle_tc", terminal_count, 0);
        check("eop_idle_dreq", dma_request, 1);
        for (int k = 0; k < 3; k++) begin
            wait_dreq(1'b1, 10, "eop_xfer_dreq");
            bus_cycle($urandom_range(1, 3), (k == 2) ? 0 : -1, 8'h00);
        end
        check("eop_tc", terminal_count, 1);
        check("eop_dreq_low", dma_request, 0);
        check("eop_level", fifo_level, 2);
        check("eop_state", dbg_state, 4);
        repeat (3) tick();
        check("done_holds_dreq", dma_request, 0);
        pulse_tc_clear();
        check("tc_cleared", terminal_count, 0);
        wait_dreq(1'b1, 4, "dreq_after_clear");
        drain_dir0();

        // IOR on empty FIFO
        check("pre_underrun", underrun, exp_underrun);
        bus_cycle(2, -1, 8'h00);
        check("underrun_set", underrun, exp_underrun);
        check("underrun_level", fifo_level, 0);
        pulse_tc_clear();
        check("underrun_clear", underrun, exp_underrun);

        // device push and bus pop on the same edge
        for (int i = 0; i < 5; i++) dev_push(8'($urandom));
        wait_dreq(1'b1, 4, "same_dreq");
        check("same_level_pre", fifo_level, 5);
        fork
            bus_cycle(1, -1, 8'h00);
            begin
                tick();
                dev_push(8'($urandom));
            end
        join
        check("same_level_post", fifo_level, 5);
        drain_dir0();

        // memory -> device: ordered bytes
        mon_on = 1'b0; enable = 1'b0;
        repeat (2) tick();
        check("idle_level", fifo_level, 0);
        direction = 1'b1; enable = 1'b1;
        repeat (2) tick();
        mon_on = 1'b1;
        wait_dreq(1'b1, 4, "dir1_dreq");
        bus_cycle(1, -1, 8'h11);
        bus_cycle(2, -1, 8'h22);
        bus_cycle(3, -1, 8'h33);
        bus_cycle(1, -1, 8'h44);
        check("dir1_level4", fifo_level, 4);
        dev_out_ready = 1'b1;
        wait_dev_drain();
        dev_out_ready = 1'b0;

        // memory -> device: random traffic with random device back-pressure
        rnd_ready_on = 1'b1;
        fork
            while (rnd_ready_on) begin
                dev_out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            begin
                int n = $urandom_range(6, 12);
                for (int i = 0; i < n; i++) begin
                    bus_cycle($urandom_range(1, 3), -1, 8'($urandom));
                    repeat ($urandom_range(0, 2)) tick();
                end
                rnd_ready_on = 1'b0;
            end
        join
        dev_out_ready = 1'b1;
        wait_dev_drain();
        dev_out_ready = 1'b0;

        // 17 writes into a 16-deep FIFO
        for (int i = 0; i < 16; i++) bus_cycle(1, -1, 8'(8'h80 + i));
        check("full_level", fifo_level, 16);
        check("full_dreq_low", dma_request, 0);
        check("pre_overrun", overrun, exp_overrun);
        bus_cycle(1, -1, 8'hEE);
        check("overrun_set", overrun, exp_overrun);
        check("overrun_level", fifo_level, 16);
        dev_out_ready = 1'b1;
        wait_dev_drain();
        dev_out_ready = 1'b0;

        // flags survive disable; reset in the middle of a strobe
        mon_on = 1'b0; enable = 1'b0;
        repeat (2) tick();
        check("idle_overrun_kept", overrun, exp_overrun);
        check("idle_state", dbg_state, 0);
        direction = 1'b0; enable = 1'b1;
        repeat (2) tick();
        dev_push(8'h3C);
        dev_push(8'hC3);
        wait_dreq(1'b1, 4, "mid_dreq");
        dma_acknowledge = 1'b1; io_read_n = 1'b0;
        @(negedge clock);
        check("mid_bus", data_bus_out, exp_q[0]);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_dreq", dma_request, 0);
        check("mid_rst_bus", data_bus_out, 8'h00);
        check("mid_rst_tc", terminal_count, 0);
        check("mid_rst_underrun", underrun, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_in_ready", dev_in_ready, 0);
        check("mid_rst_state", dbg_state, 0);
        dma_acknowledge = 1'b0; io_read_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
